// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op and state encodings for the sequential mul/div unit
//               and the control unit that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;   // signed multiply
    localparam logic [1:0] OP_MULU = 2'b01;   // unsigned multiply
    localparam logic [1:0] OP_DIV  = 2'b10;   // signed divide
    localparam logic [1:0] OP_DIVU = 2'b11;   // unsigned divide

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Conditional two's-complement negate. Gives the magnitude of a
//               signed operand, or re-applies a sign to an unsigned result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // Negate when requested; MIN maps onto itself, which is its correct magnitude
    always_comb begin
        o_val = i_neg ? (-i_val) : i_val;
    end

endmodule
`default_nettype wire

// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv_unit
// Description : Multi-cycle signed/unsigned multiply and divide. Magnitudes are
//               iterated one bit per cycle (shift-add / restoring division),
//               then signs are applied in a single fix-up cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a_raw;
    // Multiplicand (MUL) or divisor (DIV) magnitude
    logic [WIDTH-1:0]   r_opnd;
    // MUL: {partial product, multiplier}; DIV: low half holds dividend/quotient
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;

    logic               w_is_div_in;
    logic               w_signed_in;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_trial;
    logic               w_div_borrow;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Decode the incoming op into divide / signed flags
    always_comb begin
        w_is_div_in = 1'b0;
        w_signed_in = 1'b0;
        case (op)
            OP_MUL:  begin w_is_div_in = 1'b0; w_signed_in = 1'b1; end
            OP_MULU: begin w_is_div_in = 1'b0; w_signed_in = 1'b0; end
            OP_DIV:  begin w_is_div_in = 1'b1; w_signed_in = 1'b1; end
            OP_DIVU: begin w_is_div_in = 1'b1; w_signed_in = 1'b0; end
            default: begin w_is_div_in = 1'b0; w_signed_in = 1'b0; end
        endcase
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (a),
        .i_neg (w_signed_in & a[WIDTH-1]),
        .o_val (w_abs_a)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (b),
        .i_neg (w_signed_in & b[WIDTH-1]),
        .o_val (w_abs_b)
    );

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_val (r_acc),
        .i_neg (r_neg_res),
        .o_val (w_prod_fix)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .i_val (r_acc[WIDTH-1:0]),
        .i_neg (r_neg_res),
        .o_val (w_quo_fix)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val (r_rem),
        .i_neg (r_neg_rem),
        .o_val (w_rem_fix)
    );

    // One iteration step for each op: shift-add adder and restoring-divide trial subtract
    always_comb begin
        w_mul_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_div_shift  = {r_rem, r_acc[WIDTH-1]};
        w_div_borrow = (w_div_shift < {1'b0, r_opnd});
        // The true difference is below 2^WIDTH whenever it is kept, so WIDTH bits suffice
        w_div_trial  = w_div_shift[WIDTH-1:0] - r_opnd;
    end

    // Control FSM with iteration datapath and registered outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_a_raw   <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_div  <= w_is_div_in;
                        r_neg_res <= w_signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_signed_in & a[WIDTH-1];
                        r_dz      <= w_is_div_in & (b == '0);
                        r_a_raw   <= a;
                        r_opnd    <= w_is_div_in ? w_abs_b : w_abs_a;
                        r_acc     <= {{WIDTH{1'b0}}, (w_is_div_in ? w_abs_a : w_abs_b)};
                        r_rem     <= '0;
                        r_cnt     <= CNT_W'(WIDTH);
                        div_zero  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        r_rem <= w_div_borrow ? w_div_shift[WIDTH-1:0] : w_div_trial;
                        r_acc <= {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], ~w_div_borrow};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_dz) begin
                        hi       <= r_a_raw;
                        lo       <= {WIDTH{1'b1}};
                        div_zero <= 1'b1;
                    end else if (r_is_div) begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end else begin
                        hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo <= w_prod_fix[WIDTH-1:0];
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_muldiv_unit
// Description : Self-checking bench for seq_muldiv_unit: directed vector table,
//               handshake corner cases and random ops against a plain
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t tbl[10];

    seq_muldiv_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; returns {div_zero, hi, lo}
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        model = '0;
        if ((o == OP_DIV || o == OP_DIVU) && y == '0) begin
            model = {1'b1, x, {W{1'b1}}};
        end else if (o == OP_MUL) begin
            p = sx * sy;
            model = {1'b0, p};
        end else if (o == OP_MULU) begin
            p = ux * uy;
            model = {1'b0, p};
        end else if (o == OP_DIV) begin
            sq = sx / sy;
            sr = sx % sy;
            model = {1'b0, sr[W-1:0], sq[W-1:0]};
        end else begin
            p = ux / uy;
            ux = ux % uy;
            model = {1'b0, ux[W-1:0], p[W-1:0]};
        end
    endfunction

    // Drive start at a falling edge; capture happens on the next rising edge
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        chk("done_low_after_start", {63'b0, done}, 64'd0);
    endtask

    // Count falling edges until done; a missing done counts as a failure
    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            n++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag, input int n, input logic [W-1:0] eh,
                                input logic [W-1:0] el, input logic ed);
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_hi"}, {32'b0, hi}, {32'b0, eh});
        chk({tag, "_lo"}, {32'b0, lo}, {32'b0, el});
        chk({tag, "_dz"}, {63'b0, div_zero}, {63'b0, ed});
        chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int            n;
        int            dones;
        logic [2*W:0]  m;
        logic [1:0]    ro;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        tbl[0] = '{OP_MUL,  32'h00000005, 32'h00000010, 32'h00000000, 32'h00000050, 1'b0};
        tbl[1] = '{OP_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2] = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[3] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[4] = '{OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
        tbl[5] = '{OP_DIVU, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        tbl[6] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[7] = '{OP_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[8] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[9] = '{OP_DIV,  32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};

        clear = 1'b1;
        start = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        chk("reset_dz", {63'b0, div_zero}, 64'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done(n);
            check_result($sformatf("tbl%0d", i), n, tbl[i].hi, tbl[i].lo, tbl[i].dz);
            @(negedge clock);
            chk("done_one_cycle", {63'b0, done}, 64'd0);
        end

        // Back-to-back: second start issued in the done cycle
        start_op(OP_MUL, 32'hFFFFFFFD, 32'h00000007);
        wait_done(n);
        check_result("b2b_first", n, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        start_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        check_result("b2b_second", n, 32'hFFFFFFFE, 32'h00000001, 1'b0);

        // Divide by zero flag clears on the next accepted start
        @(negedge clock);
        start_op(OP_DIVU, 32'h12345678, 32'h00000000);
        wait_done(n);
        check_result("dz", n, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        start_op(OP_MUL, 32'h00000003, 32'h00000004);
        chk("dz_cleared", {63'b0, div_zero}, 64'd0);
        chk("hold_hi_dz", {32'b0, hi}, 64'h12345678);
        wait_done(n);
        check_result("after_dz", n, 32'h00000000, 32'h0000000C, 1'b0);

        // Starts while busy are ignored; hi/lo hold the previous result meanwhile
        @(negedge clock);
        start_op(OP_MUL, 32'h00000005, 32'h00000010);
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            n++;
            if (done) break;
            if (n == 5 || n == 10) begin
                op    = OP_MULU;
                a     = 32'h0000BEEF;
                b     = 32'h00001234;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (n == 10) begin
                chk("hold_hi", {32'b0, hi}, 64'h0);
                chk("hold_lo", {32'b0, lo}, 64'hC);
            end
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        check_result("ignore_start", n, 32'h00000000, 32'h00000050, 1'b0);

        // Clear mid-CALC aborts with no done
        @(negedge clock);
        start_op(OP_MUL, 32'h00001111, 32'h00002222);
        repeat (10) @(negedge clock);
        #2 clear = 1'b1;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        start_op(OP_DIV, 32'hFFFFFF9C, 32'h00000007);
        wait_done(n);
        check_result("after_abort", n, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h80000000;
                default: ;
            endcase
            m = model(ro, ra, rb);
            @(negedge clock);
            start_op(ro, ra, rb);
            wait_done(n);
            check_result($sformatf("rnd%0d_op%0d", i, ro), n, m[2*W-1:W], m[W-1:0], m[2*W]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
